// File: rtl/present_encoder_if.sv
// Handshake and data bundle between a PRESENT-80 encoder and its client.
// The master drives key/plaintext requests; the slave returns status and ciphertext.
interface present_encoder_if;
  logic        key_load;
  logic [79:0] key_in;
  logic        start;
  logic [63:0] pt_in;
  logic        busy;
  logic        done;
  logic [63:0] ct_out;

  modport master (output key_load, key_in, start, pt_in,
                  input  busy, done, ct_out);
  modport slave  (input  key_load, key_in, start, pt_in,
                  output busy, done, ct_out);
endinterface

// File: rtl/present_encoder.sv
// Iterative PRESENT-80 encryption engine: one full round per clock, then a final
// whitening step that registers the ciphertext and pulses done.
module present_encoder #(
  parameter int NR_ROUNDS = 31
) (
  input  logic            clk,
  input  logic            n_reset,
  present_encoder_if.slave bus
);

  localparam logic [4:0] LAST_ROUND = 5'(NR_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } fsm_t;

  fsm_t        fsm_r;
  logic [79:0] key_r;
  logic [79:0] rk_r;
  logic [63:0] state_r;
  logic [4:0]  round_r;
  logic [63:0] ct_r;
  logic        busy_r;
  logic        done_r;

  logic [63:0] round_out_s;
  logic [79:0] rk_next_s;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = 64'h0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    return y;
  endfunction

  // Bit i lands on (16*i) mod 63; bit 63 is a fixed point of the permutation.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = 64'h0;
    for (int i = 0; i < 63; i++) begin
      y[(16*i) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rnd);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rnd;
    return r;
  endfunction

  // Combinational round datapath and key schedule step.
  always_comb begin
    round_out_s = p_layer(s_layer(state_r ^ rk_r[79:16]));
    rk_next_s   = key_update(rk_r, round_r);
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      fsm_r   <= IDLE;
      key_r   <= 80'h0;
      rk_r    <= 80'h0;
      state_r <= 64'h0;
      round_r <= 5'd0;
      ct_r    <= 64'h0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (bus.key_load) begin
            key_r <= bus.key_in;
          end
          if (bus.start) begin
            state_r <= bus.pt_in;
            rk_r    <= bus.key_load ? bus.key_in : key_r;
            round_r <= 5'd1;
            busy_r  <= 1'b1;
            fsm_r   <= RUN;
          end
        end
        RUN: begin
          state_r <= round_out_s;
          rk_r    <= rk_next_s;
          if (round_r == LAST_ROUND) begin
            fsm_r <= FINAL;
          end else begin
            round_r <= round_r + 5'd1;
          end
        end
        FINAL: begin
          ct_r   <= state_r ^ rk_r[79:16];
          done_r <= 1'b1;
          busy_r <= 1'b0;
          fsm_r  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          fsm_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.ct_out = ct_r;

endmodule

// File: tb/tb_present_encoder.sv
// Directed-vector bench for present_encoder using published PRESENT-80 test vectors.
module tb_present_encoder;

  logic clk;
  logic n_reset;
  int   errors;
  int   checks;

  present_encoder_if bus();

  present_encoder #(.NR_ROUNDS(31)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = 80'hFFFFFFFFFFFFFFFFFFFF;
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] P1 = 64'hFFFFFFFFFFFFFFFF;

  task automatic load_key(input logic [79:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.key_in   = {$urandom, $urandom, 16'(($urandom))};
  endtask

  // Request at the next rising edge (E0); returns at the negedge just after E0.
  task automatic start_block(input logic ld, input logic [79:0] k, input logic [63:0] p);
    bus.key_in   = k;
    bus.key_load = ld;
    bus.pt_in    = p;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.key_load = 1'b0;
    bus.pt_in    = {$urandom, $urandom};
    bus.key_in   = {$urandom, $urandom, 16'(($urandom))};
  endtask

  // Counts edges after E0 until done is seen (bounded); also counts busy samples.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.ct_out !== 64'h0) begin errors++; $display("FAIL reset_ct got=%h exp=0", bus.ct_out); end
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    load_key(K0);
    start_block(1'b0, K0, P0);
    wait_done(lat, bc);
    checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency got=%0d exp=32", lat); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=32", bc); end
    checks++; if (bus.ct_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL basic_ct got=%h exp=5579C1387B228445", bus.ct_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.ct_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL basic_ct_hold got=%h exp=5579C1387B228445", bus.ct_out); end
  endtask

  task automatic test_vectors;
    int lat, bc;
    logic [79:0] kv [3];
    logic [63:0] pv [3];
    logic [63:0] ev [3];
    kv[0] = K1; pv[0] = P0; ev[0] = 64'hE72C46C0F5945049;
    kv[1] = K0; pv[1] = P1; ev[1] = 64'hA112FFC72F68417B;
    kv[2] = K1; pv[2] = P1; ev[2] = 64'h3333DCD3213210D2;
    for (int i = 0; i < 3; i++) begin
      load_key(kv[i]);
      start_block(1'b0, 80'h0, pv[i]);
      wait_done(lat, bc);
      checks++;
      if (bus.ct_out !== ev[i]) begin
        errors++; $display("FAIL vector_%0d got=%h exp=%h lat=%0d", i, bus.ct_out, ev[i], lat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_same_cycle_load;
    int lat, bc;
    load_key(K0);
    start_block(1'b1, K1, P1);
    wait_done(lat, bc);
    checks++; if (bus.ct_out !== 64'h3333DCD3213210D2) begin errors++; $display("FAIL same_cycle_ct got=%h exp=3333DCD3213210D2", bus.ct_out); end
    @(negedge clk);
    start_block(1'b0, K0, P0);
    wait_done(lat, bc);
    checks++; if (bus.ct_out !== 64'hE72C46C0F5945049) begin errors++; $display("FAIL same_cycle_key_kept got=%h exp=E72C46C0F5945049", bus.ct_out); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    int lat, bc;
    load_key(K0);
    start_block(1'b0, K0, P0);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.pt_in = P1; bus.key_load = 1'b1; bus.key_in = K1;
    @(negedge clk);
    bus.start = 1'b0; bus.key_load = 1'b0;
    wait_done(lat, bc);
    checks++; if (bus.ct_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL ignore_busy_ct got=%h exp=5579C1387B228445", bus.ct_out); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL ignore_busy_latency got=%0d exp=26", lat); end
  endtask

  // Entered at the negedge where done is high, so this start lands on E33.
  task automatic test_back_to_back;
    int lat, bc;
    start_block(1'b0, K1, P1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    repeat (10) @(negedge clk);
    checks++; if (bus.ct_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL b2b_ct_hold got=%h exp=5579C1387B228445", bus.ct_out); end
    wait_done(lat, bc);
    checks++; if (bus.ct_out !== 64'hA112FFC72F68417B) begin errors++; $display("FAIL b2b_ct got=%h exp=A112FFC72F68417B", bus.ct_out); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat, bc, done_seen;
    load_key(K1);
    start_block(1'b0, K0, P0);
    repeat (10) @(negedge clk);
    n_reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    checks++; if (bus.ct_out !== 64'h0) begin errors++; $display("FAIL abort_ct got=%h exp=0", bus.ct_out); end
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    start_block(1'b0, K1, P0);
    wait_done(lat, bc);
    checks++; if (bus.ct_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL abort_key_cleared got=%h exp=5579C1387B228445", bus.ct_out); end
    @(negedge clk);
    load_key(K1);
    start_block(1'b0, K0, P0);
    wait_done(lat, bc);
    checks++; if (bus.ct_out !== 64'hE72C46C0F5945049) begin errors++; $display("FAIL abort_restart got=%h exp=E72C46C0F5945049", bus.ct_out); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL abort_restart_latency got=%0d exp=32", lat); end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    n_reset      = 1'b0;
    bus.key_load = 1'b0;
    bus.key_in   = 80'h0;
    bus.start    = 1'b0;
    bus.pt_in    = 64'h0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_vectors;
    test_same_cycle_load;
    test_ignore_busy;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
